// File: rtl/des_pkg.sv
// DES constant tables, permutation helpers, key rotation helpers and the controller state enum.
package des_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } des_state_e;

   // Counter value of the extra ROUND cycle that applies the final swap and FP.
   localparam int unsigned FINAL_CNT = 17;

   localparam int unsigned IP_TBL [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,
      64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7
   };

   localparam int unsigned FP_TBL [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32,
      39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,
      37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,
      35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,
      33,  1, 41,  9, 49, 17, 57, 25
   };

   localparam int unsigned E_TBL [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1
   };

   localparam int unsigned P_TBL [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   localparam int unsigned PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam logic [1:0] SHIFT_SCHED [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Each box is stored row-major: index = {row, column} = {b1, b6, b2..b5}.
   localparam logic [3:0] SBOX [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
   };

   // Table bit n (1-based, bit 1 = MSB) maps to vector index WIDTH-n.
   function automatic logic [63:0] des_ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
      return y;
   endfunction

   function automatic logic [63:0] des_fp(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
      return y;
   endfunction

   function automatic logic [47:0] des_e(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
      return y;
   endfunction

   function automatic logic [31:0] des_p(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
      return y;
   endfunction

   function automatic logic [55:0] des_pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
      return y;
   endfunction

   function automatic logic [47:0] des_pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
      return y;
   endfunction

   function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
      return SBOX[box][{six[5], six[0], six[4:1]}];
   endfunction

   // Schedule entries are only ever 1 or 2.
   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: (L, R, subkey) -> (R, L ^ f(R, subkey)).
module des_round
   import des_pkg::*;
(
   input  logic [31:0] l,
   input  logic [31:0] r,
   input  logic [47:0] subkey,
   output logic [31:0] l_next_c,
   output logic [31:0] r_next_c
);

   logic [47:0] ex;
   logic [31:0] s_out;

   // Expansion, key mix and the eight S-box substitutions.
   always_comb begin
      ex    = des_e(r) ^ subkey;
      s_out = '0;
      for (int b = 0; b < 8; b++) begin
         s_out[5'(28 - 4 * b) +: 4] = sbox_lookup(3'(b), 6'(ex >> (42 - 6 * b)));
      end
   end

   assign l_next_c = r;
   assign r_next_c = l ^ des_p(s_out);

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES engine: one round per cycle, 17-cycle accept-to-result latency.
// Define DES_CBC_EN to add the iv/iv_load ports and CBC chaining; default build is ECB.
module des_iter_ctrl
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        enc1_dec0,
   input  logic [63:0] in,
   input  logic [63:0] key,
   output logic [63:0] out,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef DES_CBC_EN
   input  logic [63:0] iv,
   input  logic        iv_load,
`endif
   output logic        busy
);

   des_state_e  state_q, state_d;
   logic [4:0]  cnt_q;
   logic        enc_q;
   logic [31:0] l_q, r_q, l_nx, r_nx;
   logic [27:0] c_q, d_q, c_sh, d_sh;
   logic [47:0] subkey;
   logic [63:0] blk_in, fp_out, result;
   logic        iv_sel;
   logic        accept, round_en, finish, handoff;

`ifdef DES_CBC_EN
   logic [63:0] chain_q, ct_q;
   logic        iv_take;

   assign iv_sel  = iv_load;
   assign iv_take = (state_q == IDLE) && iv_load;
   assign blk_in  = enc1_dec0 ? (in ^ chain_q) : in;
   assign result  = enc_q ? fp_out : (fp_out ^ chain_q);
`else
   assign iv_sel  = 1'b0;
   assign blk_in  = in;
   assign result  = fp_out;
`endif

   // State register plus registered handshake/status decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         in_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_ready <= (state_d == IDLE);
         busy     <= (state_d != IDLE);
      end
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      round_en = 1'b0;
      finish   = 1'b0;
      handoff  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!iv_sel && in_valid) begin
               accept  = 1'b1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (cnt_q == 5'(FINAL_CNT)) begin
               finish  = 1'b1;
               state_d = DONE;
            end else begin
               round_en = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               handoff = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Decrypt walks the schedule backwards: K16 needs no shift, then right rotations.
   always_comb begin
      c_sh = c_q;
      d_sh = d_q;
      if (enc_q) begin
         c_sh = rotl28(c_q, SHIFT_SCHED[4'(cnt_q - 5'd1)]);
         d_sh = rotl28(d_q, SHIFT_SCHED[4'(cnt_q - 5'd1)]);
      end else if (cnt_q != 5'd1) begin
         c_sh = rotr28(c_q, SHIFT_SCHED[4'(5'd17 - cnt_q)]);
         d_sh = rotr28(d_q, SHIFT_SCHED[4'(5'd17 - cnt_q)]);
      end
   end

   assign subkey = des_pc2({c_sh, d_sh});
   assign fp_out = des_fp({r_q, l_q});

   des_round u_round (
      .l        (l_q),
      .r        (r_q),
      .subkey   (subkey),
      .l_next_c (l_nx),
      .r_next_c (r_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         l_q       <= '0;
         r_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         enc_q     <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            {l_q, r_q} <= des_ip(blk_in);
            {c_q, d_q} <= des_pc1(key);
            enc_q      <= enc1_dec0;
            cnt_q      <= 5'd1;
         end
         if (round_en) begin
            l_q   <= l_nx;
            r_q   <= r_nx;
            c_q   <= c_sh;
            d_q   <= d_sh;
            cnt_q <= cnt_q + 5'd1;
         end
         if (finish) begin
            out       <= result;
            out_valid <= 1'b1;
         end
         if (handoff) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef DES_CBC_EN
   // Chain follows the ciphertext side of each block.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
         ct_q    <= '0;
      end else begin
         if (iv_take) begin
            chain_q <= iv;
         end
         if (accept) begin
            ct_q <= in;
         end
         if (finish) begin
            chain_q <= enc_q ? fp_out : ct_q;
         end
      end
   end
`endif

endmodule

// File: doc/des_iter_ctrl.md
DES_ITER_CTRL -- requirements
Module: des_iter_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  request carries a block.
REQ-004 SHALL have: in_ready  output  1  controller can accept a block.
REQ-005 SHALL have: enc1_dec0  input  1  1 = encrypt, 0 = decrypt; sampled at accept.
REQ-006 SHALL have: in  input  64 [1:64]  plaintext or ciphertext; bit 1 is MSB.
REQ-007 SHALL have: key  input  64 [1:64]  DES key, parity bits ignored; sampled at accept.
REQ-008 SHALL have: out  output  64 [1:64]  result block.
REQ-009 SHALL have: out_valid  output  1  out holds a result.
REQ-010 SHALL have: out_ready  input  1  consumer takes the result.
REQ-011 SHALL have: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, ROUND and DONE.
REQ-013 IDLE: in_ready = 1; on in_valid the block is accepted, IP(in) is loaded into L/R, PC1(key) into C/D, mode is latched, round counter is set to 1, and the FSM goes to ROUND.
REQ-014 ROUND: one Feistel round per cycle using subkey PC2(C,D) after that round's shift; counter 1..16; after round 16 the FSM goes to DONE.
REQ-015 Encrypt key shifts SHALL be left rotations of C and D by the standard schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-016 Decrypt key shifts SHALL be: round 1 no shift, then right rotations for rounds 2..16 of 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 On entry to DONE, out SHALL be registered as FP(R16 concatenated with L16) (final swap), and out_valid = 1.
REQ-018 Latency SHALL be exactly 17 cycles from the accept edge to out_valid high.
REQ-019 DONE: out and out_valid SHALL hold stable until out_ready = 1; at that edge out_valid falls and the FSM returns to IDLE.
REQ-020 in_ready SHALL be 0 in ROUND and DONE; no new block is accepted until IDLE.
REQ-021 A result SHALL never be overwritten or dropped while out_ready is low.
REQ-022 Changes on in, key or enc1_dec0 after the accept edge SHALL have no effect on the result in flight.

Reset
REQ-023 While rst = 1, on the clock edge: state is IDLE, in_ready = 1 after reset release, out_valid = 0, busy = 0, out = 0, round counter = 0, and L/R/C/D = 0.
REQ-024 Reset asserted mid-operation (ROUND or DONE) SHALL abort the block with no output; the next accept after release SHALL proceed normally.

Configuration
REQ-025 Macro DES_CBC_EN, when defined, SHALL add the following ports: iv input 64, iv_load input 1, and a 64-bit chain register.
REQ-026 With DES_CBC_EN, iv_load in IDLE SHALL load chain from iv; iv_load has priority over in_valid in the same cycle, and no block is accepted in that cycle.
REQ-027 With DES_CBC_EN, encrypt SHALL apply IP to (in XOR chain) and set chain to the result at DONE.
REQ-028 With DES_CBC_EN, decrypt SHALL output FP(...) XOR chain and set chain to the accepted ciphertext.
REQ-029 With DES_CBC_EN, reset SHALL clear chain to 0.
REQ-030 Without DES_CBC_EN, the block SHALL operate in pure ECB mode and the iv and iv_load ports and the chain register SHALL be absent.

Structure
REQ-031 Package des_pkg SHALL hold the IP, FP, E, P, PC1 and PC2 tables, the S-boxes, the 16-entry shift schedule and the FSM state enum.
REQ-032 Sub-module des_round (combinational: L, R, 48-bit subkey -> next L, next R) SHALL be instantiated once.
REQ-033 The key schedule, counter and FSM SHALL reside in des_iter_ctrl.

Verification
REQ-034 Encrypt: key AABB09182736CCDD, in 123456ABCD132536 -> out C0B7A8D05F3A829C, out_valid exactly 17 cycles after accept.
REQ-035 Decrypt: same key, in C0B7A8D05F3A829C -> out 123456ABCD132536.
REQ-036 Encrypt: key 133457799BBCDFF1, in 0123456789ABCDEF -> out 85E813540F0AB405.
REQ-037 Back-pressure: out_ready held 0 for 10 cycles after out_valid -> out stable, in_ready 0 with in_valid high, and the block is accepted the cycle after the handshake.
REQ-038 Reset at round 8, then a new encrypt of REQ-036 -> no out_valid for the aborted block, and the correct 85E813540F0AB405 result.
REQ-039 With DES_CBC_EN: iv 0 then two blocks 123456ABCD132536 -> first output C0B7A8D05F3A829C; second output equals ECB(123456ABCD132536 XOR C0B7A8D05F3A829C); decrypt of both restores the plaintext.
